// File: rtl/teclado_pkg.sv
// Shared definitions for the keypad path: key codes used by the driver and
// the entry sequencer, and the sequencer state encoding.
package teclado_pkg;

   localparam logic [4:0] TECLA_MAX_DIGITO = 5'd9;
   localparam logic [4:0] TECLA_BORRAR     = 5'd10;
   localparam logic [4:0] TECLA_CANCELAR   = 5'd11;

   typedef enum logic [1:0] {
      ESPERA   = 2'd0,
      CAPTURA  = 2'd1,
      COMPLETO = 2'd2,
      ERROR    = 2'd3
   } estado_t;

   // Codes 0-9 are numeric; bit 4 set pushes the value above 9 as well.
   function automatic logic es_numerica(input logic [4:0] codigo);
      return (codigo <= TECLA_MAX_DIGITO);
   endfunction

endpackage

// File: rtl/controlador_ingreso_timeout.sv
// Idle timer: loads CICLOS-1 on clear and counts down while enabled.
// expira_o pulses for the one enabled, non-cleared cycle in which the count
// sits at zero; the counter reloads on that same edge.
module contador_timeout #(
   parameter int CICLOS = 10
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expira_o
);

   localparam int W = (CICLOS > 1) ? $clog2(CICLOS) : 1;
   localparam logic [W-1:0] CARGA = W'(CICLOS - 1);

   logic [W-1:0] cnt_q, cnt_d;

   assign expira_o = en_i & ~clr_i & (cnt_q == '0);

   // Next count: reload on clear or expiry, otherwise decrement when enabled.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || expira_o) begin
         cnt_d = CARGA;
      end else if (en_i) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   // Count register with synchronous reset to the full reload value.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= CARGA;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/controlador_ingreso.sv
// Entry sequencer: collects key strobes into a BCD number, supports delete,
// cancel, enter and idle timeout, and hands the result over with valid/ack.
//
// state    | meaning
// ESPERA   | idle, no digits held, scan running
// CAPTURA  | digits being collected, idle timer running
// COMPLETO | entry frozen, valido high, scan gated until ack
// ERROR    | empty enter or timeout, error high, scan gated until ack
module controlador_ingreso
   import teclado_pkg::*;
#(
   parameter  int N_DIGITOS      = 4,
   parameter  int TIMEOUT_CICLOS = 50000000,
   localparam int CW             = $clog2(N_DIGITOS + 1)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   tecla_valida_i,
   input  logic [4:0]             digito_i,
   input  logic                   enter_i,
   input  logic                   ack_i,
   output logic                   scan_en_o,
   output logic [4*N_DIGITOS-1:0] numero_o,
   output logic [CW-1:0]          cuenta_o,
   output logic                   valido_o,
   output logic                   error_o,
   output logic                   ocupado_o
);

   localparam int NW = 4 * N_DIGITOS;

   estado_t        estado_q, estado_d;
   logic [NW-1:0]  numero_q, numero_d;
   logic [CW-1:0]  cuenta_q, cuenta_d;
   logic           valido_q, error_q, ocupado_q, scan_en_q;

   logic           es_digito, es_borrar, es_cancelar, hay_lugar;
   logic           clr_timeout, en_timeout, expira;

   assign es_digito   = tecla_valida_i & es_numerica(digito_i);
   assign es_borrar   = tecla_valida_i & (digito_i == TECLA_BORRAR);
   assign es_cancelar = tecla_valida_i & (digito_i == TECLA_CANCELAR);
   assign hay_lugar   = (cuenta_q < CW'(N_DIGITOS));

   // A full-entry digit is not an accepted key, so it does not restart the timer.
   assign en_timeout  = (estado_q == CAPTURA);
   assign clr_timeout = ~en_timeout | enter_i | (es_digito & hay_lugar)
                        | es_borrar | es_cancelar;

   contador_timeout #(
      .CICLOS (TIMEOUT_CICLOS)
   ) u_timeout (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (clr_timeout),
      .en_i     (en_timeout),
      .expira_o (expira)
   );

   // Next state and datapath; enter outranks a key, a key outranks timeout.
   always_comb begin
      estado_d = estado_q;
      numero_d = numero_q;
      cuenta_d = cuenta_q;
      case (estado_q)
         ESPERA: begin
            if (enter_i) begin
               estado_d = ERROR;
            end else if (es_digito) begin
               numero_d = NW'(numero_q << 4) | NW'(digito_i[3:0]);
               cuenta_d = cuenta_q + CW'(1);
               estado_d = CAPTURA;
            end
         end
         CAPTURA: begin
            if (enter_i) begin
               estado_d = COMPLETO;
            end else if (es_digito) begin
               if (hay_lugar) begin
                  numero_d = NW'(numero_q << 4) | NW'(digito_i[3:0]);
                  cuenta_d = cuenta_q + CW'(1);
               end
            end else if (es_borrar) begin
               numero_d = numero_q >> 4;
               cuenta_d = cuenta_q - CW'(1);
               if (cuenta_q == CW'(1)) begin
                  estado_d = ESPERA;
               end
            end else if (es_cancelar) begin
               numero_d = '0;
               cuenta_d = '0;
               estado_d = ESPERA;
            end else if (expira) begin
               numero_d = '0;
               cuenta_d = '0;
               estado_d = ERROR;
            end
         end
         COMPLETO: begin
            if (ack_i) begin
               numero_d = '0;
               cuenta_d = '0;
               estado_d = ESPERA;
            end
         end
         ERROR: begin
            if (ack_i) begin
               estado_d = ESPERA;
            end
         end
         default: begin
            estado_d = ESPERA;
            numero_d = '0;
            cuenta_d = '0;
         end
      endcase
   end

   // State, datapath and status flags; flags are decoded from the next state
   // so every output comes straight from a flop.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         estado_q  <= ESPERA;
         numero_q  <= '0;
         cuenta_q  <= '0;
         valido_q  <= 1'b0;
         error_q   <= 1'b0;
         ocupado_q <= 1'b0;
         scan_en_q <= 1'b1;
      end else begin
         estado_q  <= estado_d;
         numero_q  <= numero_d;
         cuenta_q  <= cuenta_d;
         valido_q  <= (estado_d == COMPLETO);
         error_q   <= (estado_d == ERROR);
         ocupado_q <= (estado_d == CAPTURA);
         scan_en_q <= (estado_d == ESPERA) || (estado_d == CAPTURA);
      end
   end

   assign numero_o  = numero_q;
   assign cuenta_o  = cuenta_q;
   assign valido_o  = valido_q;
   assign error_o   = error_q;
   assign ocupado_o = ocupado_q;
   assign scan_en_o = scan_en_q;

endmodule

// File: doc/controlador_ingreso.md
Name: controlador_ingreso

Overview:
- Sequencer that sits directly after Driver_teclado and turns single key strobes into a multi-digit BCD entry.
- Supports delete, cancel, enter and an inactivity timeout.
- Gates the driver's column scan while a finished entry is waiting for the consumer.
- Hands the completed number to the system FSM (lock/validation logic) through a valid/ack handshake.

Parameters:
N_DIGITOS, 4, maximum digits per entry (1..8)
TIMEOUT_CICLOS, 50000000, idle cycles in CAPTURA before abort (1 s at 50 MHz)
CW, $clog2(N_DIGITOS+1), width of cuenta (derived, not overridable)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
tecla_valida  input  1  one-cycle strobe from driver: digito is a new key
digito  input  5  key code; 0-9 numeric, 10 borrar, 11 cancelar, others ignored
enter  input  1  one-cycle strobe from driver: entry confirmed
ack  input  1  consumer acknowledges valido or error
scan_en  output  1  enables driver column scan
numero  output  4*N_DIGITOS  BCD entry, newest digit in [3:0]
cuenta  output  CW  digits currently held
valido  output  1  entry complete, numero stable
error  output  1  entry aborted (empty enter or timeout)
ocupado  output  1  high in CAPTURA

Behaviour:
- Reset (rst=1 at clk edge): state ESPERA, numero=0, cuenta=0, valido=0, error=0, ocupado=0, scan_en=1, timeout counter=0. Reset wins over every other input, including mid-entry.
- All outputs are registered. A key's effect is visible one cycle after the tecla_valida/enter edge.
- Digit shift:
  - numero <= {numero[4N-5:0], digito[3:0]}
  - cuenta <= cuenta+1
- Borrar shift:
  - numero <= {4'h0, numero[4N-1:4]}
  - cuenta <= cuenta-1
- Priority within one cycle: rst > enter > tecla_valida > timeout. When enter and tecla_valida are both high, the key is discarded.
- Timeout counter:
  - Counts only in CAPTURA.
  - Cleared on every accepted key or enter.
  - Expiry occurs when the count reaches TIMEOUT_CICLOS-1 with no event in that cycle.
- State ESPERA (cuenta=0, scan_en=1):
  - Digit: shift in, go to CAPTURA.
  - Enter: go to ERROR.
  - Borrar, cancelar, other codes: ignored.
- State CAPTURA (ocupado=1, scan_en=1):
  - Digit with cuenta<N: shift in.
  - Digit with cuenta==N: ignored; numero and cuenta unchanged, no error.
  - Borrar: right shift. If cuenta becomes 0, go to ESPERA.
  - Cancelar: numero=0, cuenta=0, go to ESPERA.
  - Enter: go to COMPLETO.
  - Timeout expiry: numero=0, cuenta=0, go to ERROR.
- State COMPLETO (valido=1, scan_en=0):
  - numero and cuenta are frozen. All keys and enter are ignored.
  - ack: numero=0, cuenta=0, valido=0, go to ESPERA.
  - ack arriving on the same cycle COMPLETO is entered is not seen; ack is sampled from the first cycle valido=1.
- State ERROR (error=1, scan_en=0, numero=0):
  - Keys are ignored.
  - ack: error=0, go to ESPERA.
- valido and error are never high together.
- ack outside COMPLETO/ERROR has no effect.
- digito is sampled only when tecla_valida=1. Bit 4 set, or a value of 12-31, means the key is ignored.

Decomposition:
- Shared package teclado_pkg:
  - Key code constants: TECLA_BORRAR=5'd10, TECLA_CANCELAR=5'd11.
  - State encoding localparams: ESPERA, CAPTURA, COMPLETO, ERROR.
  - Driver_teclado should adopt the same code constants.
- Sub-module contador_timeout: parameterised down-counter with clear, enable and one-cycle expiry output; reusable by the display blink logic.
- FSM and BCD shift register stay in controlador_ingreso.

Test Plan:
- Reset, keys 1,2,3, enter -> one cycle after enter: numero=16'h0123, cuenta=3, valido=1, scan_en=0. Then ack -> numero=0, cuenta=0, ESPERA.
- Keys 4,5,6,7,8 with N=4 -> numero=16'h4567, cuenta=4. The 5th key is ignored. Enter -> valido=1.
- Keys 9,2, borrar, borrar -> numero=16'h0009, then 0, cuenta=0, state ESPERA. Borrar in ESPERA -> no change.
- Enter in ESPERA -> error=1, scan_en=0. A key 5 during ERROR is ignored. ack -> error=0.
- With TIMEOUT_CICLOS=10: key 7, then no input for 10 cycles -> error=1, numero=0. Same setup with a key at cycle 9 -> counter restarts, no error.
- Key 3 and enter in the same cycle from CAPTURA holding 16'h0001 -> COMPLETO with numero=16'h0001 (key dropped). rst asserted mid-entry -> all outputs return to reset values next edge.
